regfile: RTL and testbench



---
 rtl/regfile.sv | 38 +++
 tb/tb_regfile.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32xWIDTH MIPS register file, r0 hardwired to zero, two combinational read ports, optional write bypass, sync clear sequencer
module regfile #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic [4:0]       wn,
  input  logic [WIDTH-1:0] d,
  input  logic             we,
  output logic             ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [WIDTH-1:0] mem [32];
  logic wr;
  always_comb begin
    state_n = (state == CLEAR && cnt == 5'd31) ? RUN : state;
    ready   = state == RUN;
    wr      = ready && we && wn != 5'd0;
    qa      = (ready && rna != 5'd0) ? ((BYPASS && wr && wn == rna) ? d : mem[rna]) : '0;
    qb      = (ready && rnb != 5'd0) ? ((BYPASS && wr && wn == rnb) ? d : mem[rnb]) : '0;
  end
  always_ff @(posedge clk)
    state <= rst ? CLEAR : state_n;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (state == CLEAR) begin
      mem[cnt] <= '0;
      cnt <= cnt + 5'd1;
    end else if (wr) mem[wn] <= d;
  end
endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rna = '0, rnb = '0, wn = '0;
  logic [31:0] d = '0;
  logic we = 1'b0;
  logic [31:0] qa1, qb1, qa0, qb0;
  logic ready1, ready0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile #(.WIDTH(32), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
    .wn(wn), .d(d), .we(we), .ready(ready1));
  regfile #(.WIDTH(32), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
    .wn(wn), .d(d), .we(we), .ready(ready0));

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] qa0;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // after rst is released, ready must stay low for 31 edges and rise on the 32nd
  task automatic clear_run(input string nm);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick;
      chk($sformatf("%s ready1 edge %0d", nm, i), {31'd0, ready1}, {31'd0, i == 32});
      chk($sformatf("%s ready0 edge %0d", nm, i), {31'd0, ready0}, {31'd0, i == 32});
      if (i < 32) begin
        rna = 5'd9;
        rnb = 5'd31;
        #1;
        chk($sformatf("%s qa in clear %0d", nm, i), qa1, 32'd0);
        chk($sformatf("%s qb in clear %0d", nm, i), qb1, 32'd0);
      end
    end
    we = 1'b0;
  endtask

  task automatic all_zero(input string nm);
    for (int r = 1; r < 32; r++) begin
      rna = r[4:0];
      rnb = 5'(32 - r);
      #1;
      chk($sformatf("%s qa r%0d", nm, r), qa1, 32'd0);
      chk($sformatf("%s qb r%0d", nm, 32 - r), qb1, 32'd0);
    end
  endtask

  task automatic preload_garbage;
    for (int r = 1; r < 32; r++) begin
      we = 1'b1;
      wn = r[4:0];
      d  = 32'hA5A50000 | r;
      tick;
    end
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h1234,     5'd0, 5'd0,  32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b1, 5'd31, 32'h00400008, 5'd0, 5'd31, 32'h0,        32'h00400008, 32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd31,5'd31, 32'h00400008, 32'h00400008, 32'h00400008};
    vecs[5]  = '{1'b1, 5'd7,  32'h11,       5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b1, 5'd7,  32'h22,       5'd7, 5'd7,  32'h22,       32'h22,       32'h11};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd0,  32'h22,       32'h0,        32'h22};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd1, 5'd2,  32'h0,        32'h0,        32'h0};
    vecs[9]  = '{1'b0, 5'd5,  32'hFFFF,     5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 5'd3,  32'hAA,       5'd3, 5'd5,  32'hAA,       32'hDEADBEEF, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd31, 32'hAA,       32'h00400008, 32'hAA};

    tick;
    tick;
    clear_run("init");
    preload_garbage;
    rst = 1'b1;
    tick;
    chk("ready after rst edge", {31'd0, ready1}, 32'd0);
    tick;
    clear_run("clear");
    all_zero("clear");

    for (int i = 0; i < 12; i++) begin
      we  = vecs[i].we;
      wn  = vecs[i].wn;
      d   = vecs[i].d;
      rna = vecs[i].rna;
      rnb = vecs[i].rnb;
      #1;
      chk($sformatf("vec%0d qa", i), qa1, vecs[i].qa);
      chk($sformatf("vec%0d qb", i), qb1, vecs[i].qb);
      chk($sformatf("vec%0d qa nobypass", i), qa0, vecs[i].qa0);
      tick;
    end
    we = 1'b0;
    rna = 5'd7;
    rnb = 5'd7;
    #1;
    chk("r7 stored bypass", qa1, 32'h22);
    chk("r7 stored nobypass", qb0, 32'h22);

    rna = 5'd3;
    rst = 1'b1;
    tick;
    chk("mid-run ready drop", {31'd0, ready1}, 32'd0);
    chk("mid-run qa forced 0", qa1, 32'd0);
    clear_run("midrun");
    rna = 5'd3;
    #1;
    chk("r3 after midrun clear", qa1, 32'd0);

    preload_garbage;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    chk("ready low mid-clear", {31'd0, ready1}, 32'd0);
    rst = 1'b1;
    tick;
    we = 1'b1;
    wn = 5'd9;
    d  = 32'h55555555;
    clear_run("midclear");
    all_zero("midclear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
